// File: rtl/ifid_skid_stage.sv
// ifid_skid_stage: IF/ID stage with valid/ready handshake, one-entry skid buffer, flush and NOP fill
module ifid_skid_stage #(
  parameter int INSTR_W = 32,
  parameter int ADDR_W = 14,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h00000033,
  parameter bit NOP_ON_EMPTY = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  addr_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  addr_o,
  output logic [1:0]         occupancy
);
  logic               valid_m_q, valid_m_d, valid_s_q, valid_s_d, in_ready_q;
  logic [INSTR_W-1:0] instr_m_q, instr_m_d, instr_s_q, instr_s_d;
  logic [ADDR_W-1:0]  addr_m_q, addr_m_d, addr_s_q, addr_s_d;
  logic [1:0]         occ_q;
  logic               acc, pop;
  assign acc = in_valid & in_ready_q;
  assign pop = valid_m_q & out_ready;
  always_comb begin
    valid_m_d = valid_m_q;
    valid_s_d = valid_s_q;
    instr_m_d = instr_m_q;
    addr_m_d  = addr_m_q;
    instr_s_d = instr_s_q;
    addr_s_d  = addr_s_q;
    if (flush_i) begin
      valid_m_d = 1'b0;
      valid_s_d = 1'b0;
      instr_m_d = NOP_INSTR;
      addr_m_d  = '0;
    end else if (!valid_m_q || (!valid_s_q && pop)) begin
      valid_m_d = acc;
      instr_m_d = acc ? instr_i : instr_m_q;
      addr_m_d  = acc ? addr_i : addr_m_q;
    end else if (!valid_s_q) begin
      valid_s_d = acc;
      instr_s_d = acc ? instr_i : instr_s_q;
      addr_s_d  = acc ? addr_i : addr_s_q;
    end else if (pop) begin
      valid_s_d = 1'b0;
      instr_m_d = instr_s_q;
      addr_m_d  = addr_s_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_m_q  <= 1'b0;
      valid_s_q  <= 1'b0;
      instr_m_q  <= NOP_INSTR;
      addr_m_q   <= '0;
      instr_s_q  <= NOP_INSTR;
      addr_s_q   <= '0;
      in_ready_q <= 1'b1;
      occ_q      <= 2'd0;
    end else begin
      valid_m_q  <= valid_m_d;
      valid_s_q  <= valid_s_d;
      instr_m_q  <= instr_m_d;
      addr_m_q   <= addr_m_d;
      instr_s_q  <= instr_s_d;
      addr_s_q   <= addr_s_d;
      in_ready_q <= !valid_s_d;
      occ_q      <= {1'b0, valid_m_d} + {1'b0, valid_s_d};
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = valid_m_q;
  assign occupancy = occ_q;
  assign instr_o   = (NOP_ON_EMPTY && !valid_m_q) ? NOP_INSTR : instr_m_q;
  assign addr_o    = (NOP_ON_EMPTY && !valid_m_q) ? '0 : addr_m_q;
  a_skid_implies_main: assert property (@(posedge clk) disable iff (!rst_n) !(valid_s_q && !valid_m_q));
endmodule

// File: tb/tb_ifid_skid_stage.sv
// tb_ifid_skid_stage: randomized scoreboard bench against a queue-based model of the stage
module tb_ifid_skid_stage;
  localparam logic [31:0] NOP = 32'h00000033;
  typedef struct {logic [31:0] i; logic [13:0] a;} ent_t;
  logic clk = 1'b0, rst_n = 1'b0, flush_i = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] instr_i = '0;
  logic [13:0] addr_i = '0;
  logic in_ready0, out_valid0, in_ready1, out_valid1;
  logic [31:0] instr_o0, instr_o1;
  logic [13:0] addr_o0, addr_o1;
  logic [1:0] occ0, occ1;
  int errors = 0, checks = 0;
  ent_t q[$];
  logic [31:0] last_i = NOP;
  logic [13:0] last_a = '0;
  bit p, a;
  ifid_skid_stage #(.NOP_ON_EMPTY(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_valid(in_valid), .in_ready(in_ready0),
    .instr_i(instr_i), .addr_i(addr_i), .out_valid(out_valid0), .out_ready(out_ready),
    .instr_o(instr_o0), .addr_o(addr_o0), .occupancy(occ0));
  ifid_skid_stage #(.NOP_ON_EMPTY(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_valid(in_valid), .in_ready(in_ready1),
    .instr_i(instr_i), .addr_i(addr_i), .out_valid(out_valid1), .out_ready(out_ready),
    .instr_o(instr_o1), .addr_o(addr_o1), .occupancy(occ1));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  // Reference: the stage is a FIFO of depth 2 whose accept is gated by its registered fill level
  always @(posedge clk) begin
    if (!rst_n || flush_i) begin
      q.delete();
      last_i = NOP;
      last_a = '0;
    end else begin
      p = q.size() > 0 && out_ready;
      a = in_valid && q.size() < 2;
      if (p) void'(q.pop_front());
      if (a) q.push_back('{instr_i, addr_i});
    end
    if (q.size() > 0) begin
      last_i = q[0].i;
      last_a = q[0].a;
    end
  end
  always @(posedge clk) begin
    #1;
    chk("out_valid", {63'd0, out_valid0}, {63'd0, q.size() > 0});
    chk("in_ready", {63'd0, in_ready0}, {63'd0, q.size() < 2});
    chk("occupancy", {62'd0, occ0}, 64'(q.size()));
    chk("instr_o", {32'd0, instr_o0}, {32'd0, q.size() > 0 ? q[0].i : NOP});
    chk("addr_o", {50'd0, addr_o0}, {50'd0, q.size() > 0 ? q[0].a : 14'd0});
    chk("hold_out_valid", {63'd0, out_valid1}, {63'd0, q.size() > 0});
    chk("hold_occupancy", {62'd0, occ1}, 64'(q.size()));
    chk("hold_instr_o", {32'd0, instr_o1}, {32'd0, last_i});
    chk("hold_addr_o", {50'd0, addr_o1}, {50'd0, last_a});
  end
  task automatic cyc(input bit r, input bit f, input bit iv, input logic [31:0] ins,
                     input logic [13:0] ad, input bit ordy);
    @(negedge clk);
    rst_n = r; flush_i = f; in_valid = iv; instr_i = ins; addr_i = ad; out_ready = ordy;
  endtask
  initial begin
    cyc(0, 0, 1, 32'h00500093, 14'h0, 0);
    cyc(0, 0, 1, 32'h00500093, 14'h0, 0);
    for (int k = 0; k < 4; k++) cyc(1, 0, 1, 32'h1000 + k, 14'(4 * k), 1);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 1, 32'hA, 14'h10, 0);
    cyc(1, 0, 1, 32'hB, 14'h14, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 1, 32'hA, 14'h10, 0);
    cyc(1, 0, 1, 32'hB, 14'h14, 0);
    cyc(1, 1, 1, 32'hC, 14'h18, 0);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 1, 32'hA, 14'h10, 0);
    cyc(1, 0, 1, 32'hB, 14'h14, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 32'hD, 14'h20, 0);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 1, 32'hE, 14'h24, 0);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3000; k++)
      cyc($urandom_range(199) != 0, $urandom_range(19) == 0, $urandom_range(9) < 7,
          $urandom, 14'($urandom), $urandom_range(9) < 6);
    cyc(1, 0, 0, 0, 0, 1);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ifid_skid_stage.md
Name: ifid_skid_stage

Overview:
- Parametrised IF/ID pipeline stage that replaces the plain IF/ID register.
- Adds a valid/ready handshake on both sides, a one-entry skid buffer so a downstream stall never drops a fetched instruction, and a flush input for jumps and mispredicts.
- When no valid instruction is held, the stage presents a configurable NOP so the decoder always sees a legal instruction.
- Sits between the fetch unit (upstream) and the decoder (downstream).

Parameters:
- INSTR_W, 32, instruction width in bits.
- ADDR_W, 14, instruction address width in bits.
- NOP_INSTR, 32'h00000033, instruction presented when empty, after flush and after reset (add x0,x0,x0).
- NOP_ON_EMPTY, 1: 1 = instr_o/addr_o show NOP_INSTR/0 whenever out_valid=0; 0 = they hold the last value.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- flush_i  input  1  jump/flush; discards all held entries and any same-cycle input.
- in_valid  input  1  fetch presents instr_i/addr_i.
- in_ready  output  1  stage can accept; registered; equals skid-empty.
- instr_i  input  INSTR_W  fetched instruction.
- addr_i  input  ADDR_W  fetched instruction address.
- out_valid  output  1  instr_o/addr_o hold a valid entry.
- out_ready  input  1  decoder consumes the entry.
- instr_o  output  INSTR_W  instruction to decode.
- addr_o  output  ADDR_W  address to decode.
- occupancy  output  2  entries held, 0..2.

Behaviour:
- Storage:
  - Main entry M (valid_m, instr_m, addr_m) drives the outputs.
  - Skid entry S (valid_s, instr_s, addr_s).
  - Order is preserved: S is always younger than M.
- Handshakes:
  - acc = in_valid & in_ready; pop = out_valid & out_ready.
  - in_ready = !valid_s. It is a register and never combinationally depends on out_ready.
  - out_valid = valid_m.
- Reset (rst_n=0 at an edge):
  - valid_m = valid_s = 0; in_ready=1; out_valid=0; instr_o=NOP_INSTR; addr_o=0; occupancy=0.
  - Reset overrides flush and all handshakes. Reset mid-stream discards both entries.
- Flush (flush_i=1, rst_n=1):
  - Next cycle: valid_m = valid_s = 0; instr_o=NOP_INSTR; addr_o=0 regardless of NOP_ON_EMPTY.
  - Any same-cycle acc is dropped. A same-cycle pop still counts as consumed by the decoder.
  - in_ready=1 the following cycle.
- Normal update (rst_n=1, flush_i=0), state → next state:
  - M empty, acc → M=in. Latency 1: out_valid rises the cycle after acc.
  - M empty, no acc → unchanged.
  - M full, S empty, pop & acc → M=in.
  - M full, S empty, pop & !acc → M empty.
  - M full, S empty, !pop & acc → S=in; in_ready=0 next cycle.
  - M full, S empty, !pop & !acc → hold.
  - M full, S full, pop → M=S, S empty; in_ready=1 next cycle. acc is impossible here because in_ready=0.
  - M full, S full, !pop → hold both.
  - M empty with S full is unreachable and must be covered by an assertion.
- Outputs when valid_m=0:
  - NOP_ON_EMPTY=1: instr_o=NOP_INSTR, addr_o=0.
  - NOP_ON_EMPTY=0: hold last presented values, except after reset/flush, when they are NOP_INSTR/0.
- occupancy = valid_m + valid_s, registered, consistent with state every cycle.
- Full throughput: with in_valid=out_ready=1 continuously, one instruction per cycle and S is never used.
- A stalled output is never allowed to change: while out_valid=1 & out_ready=0, instr_o/addr_o are stable.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1, instr_i=32'h00500093 → out_valid=0, instr_o=32'h00000033, addr_o=0, in_ready=1, occupancy=0; after release, first accept appears on the outputs 1 cycle later.
- Streaming: out_ready=1, addresses 0x0,0x4,0x8,0xC accepted on consecutive cycles → same instructions appear on the outputs on 4 consecutive cycles in order; occupancy never exceeds 1; in_ready stays 1.
- Stall/skid: out_ready=0 with two accepts (A@0x10, B@0x14) → occupancy=2, in_ready=0, instr_o=A held stable; raise out_ready → A then B on consecutive cycles; in_ready=1 the cycle after A pops.
- Flush with full buffer: occupancy=2 and flush_i=1 with in_valid=1 (C@0x18) → next cycle out_valid=0, instr_o=32'h00000033, addr_o=0, occupancy=0; C is never output.
- Reset mid-stall: occupancy=2, rst_n=0 for 1 cycle → all reset values; the next accepted D@0x20 is the first valid output, with no stale A/B.
- NOP_ON_EMPTY=0 instance: pop last entry E@0x24 with no new input → out_valid=0 and instr_o/addr_o still show E/0x24; then flush → instr_o=32'h00000033, addr_o=0.
